// File: rtl/uart_pkg.sv
// uart_pkg: state encodings and bit-timing helpers shared by uart_rx and uart_tx
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      START    = 2'd1,
      REC_BYTE = 2'd2,
      STOP     = 2'd3
   } rx_state_t;

   typedef enum logic [1:0] {
      TX_IDLE      = 2'd0,
      TX_START     = 2'd1,
      TX_SEND_BYTE = 2'd2,
      TX_STOP      = 2'd3
   } tx_state_t;

   localparam int CYCLE_MIN = 8;
   localparam int CYCLE_MAX = 65535;

   // clock cycles per serial bit, clock given in MHz
   function automatic int cycle_of(input int clk_mhz, input int baud);
      return (clk_mhz * 1000000) / baud;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for a single asynchronous input
module sync_2ff #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= RST_VAL;
         q    <= RST_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with a one-byte output holding register
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLK_FREQUENCY = 50,
   parameter int BAUD_RATE     = 115200
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx_pin,
   output logic [7:0] rx_data,
   output logic       rx_data_valid,
   input  logic       rx_data_ready,
   output logic       frame_err,
   output logic       overrun
);

   localparam int          CYCLE     = cycle_of(CLK_FREQUENCY, BAUD_RATE);
   localparam logic [15:0] HALF_LAST = 16'(CYCLE / 2 - 1);
   localparam logic [15:0] BIT_LAST  = 16'(CYCLE - 1);

   if (CYCLE < CYCLE_MIN || CYCLE > CYCLE_MAX) begin : g_cycle_range
      $error("uart_rx: clocks per bit out of range");
   end

   rx_state_t   state, state_nxt;
   logic [15:0] cycle_cnt, cycle_cnt_nxt;
   logic [2:0]  bit_cnt;
   logic [7:0]  shift;
   logic        rx_s, rx_prev;
   logic        fall, half_hit, bit_hit;
   logic        bit_take, commit, stop_bad;

   sync_2ff #(.RST_VAL(1'b1)) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (rx_pin),
      .q     (rx_s)
   );

   assign fall     = rx_prev & ~rx_s;
   assign half_hit = cycle_cnt == HALF_LAST;
   assign bit_hit  = cycle_cnt == BIT_LAST;

   always_comb begin
      state_nxt = state;
      bit_take  = 1'b0;
      commit    = 1'b0;
      stop_bad  = 1'b0;
      case (state)
         IDLE:     state_nxt = fall ? START : IDLE;
         START:    if (half_hit) state_nxt = rx_s ? IDLE : REC_BYTE;
         REC_BYTE: begin
            bit_take = bit_hit;
            if (bit_hit && bit_cnt == 3'd7) state_nxt = STOP;
         end
         STOP:     if (bit_hit) begin
            state_nxt = IDLE;
            commit    = rx_s;
            stop_bad  = ~rx_s;
         end
         default:  state_nxt = IDLE;
      endcase
      // bit_hit doubles as the per-bit wrap while staying in REC_BYTE
      cycle_cnt_nxt = (state_nxt != state || state == IDLE || bit_hit) ? 16'd0 : cycle_cnt + 16'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cycle_cnt <= '0;
         bit_cnt   <= '0;
         shift     <= '0;
         rx_prev   <= 1'b1;
      end else begin
         state     <= state_nxt;
         cycle_cnt <= cycle_cnt_nxt;
         rx_prev   <= rx_s;
         if (bit_take) begin
            shift[bit_cnt] <= rx_s;
            bit_cnt        <= bit_cnt + 3'd1;
         end
      end
   end

   // a commit always wins over a consume, so valid never drops on a new byte
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_data       <= '0;
         rx_data_valid <= 1'b0;
         frame_err     <= 1'b0;
         overrun       <= 1'b0;
      end else begin
         frame_err     <= stop_bad;
         overrun       <= commit & rx_data_valid & ~rx_data_ready;
         rx_data_valid <= commit | (rx_data_valid & ~rx_data_ready);
         if (commit) rx_data <= shift;
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: table-driven and randomized checks of uart_rx against a frame-level model
module tb_uart_rx;

   localparam int CYC_D = 434;
   localparam int CYC_F = 16;

   typedef struct {
      logic [7:0] b;
      logic       stop;
      logic       consume;
      logic       exp_valid;
      logic [7:0] exp_data;
      int         exp_rise;
      int         exp_ferr;
      int         exp_ovr;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       rx_d, ready_d, valid_d, ferr_d, ovr_d;
   logic [7:0] data_d;
   logic       rx_f, ready_f, valid_f, ferr_f, ovr_f;
   logic [7:0] data_f;

   int n_checks = 0;
   int n_fail   = 0;

   int rises_d = 0, ferr_d_n = 0, ovr_d_n = 0, ferr_f_n = 0, ovr_f_n = 0;
   logic vd_q = 1'b0;
   logic [7:0] got_q[$];

   uart_rx dut_d (
      .clk(clk), .rst_n(rst_n), .rx_pin(rx_d), .rx_data(data_d),
      .rx_data_valid(valid_d), .rx_data_ready(ready_d),
      .frame_err(ferr_d), .overrun(ovr_d)
   );

   uart_rx #(.CLK_FREQUENCY(2), .BAUD_RATE(125000)) dut_f (
      .clk(clk), .rst_n(rst_n), .rx_pin(rx_f), .rx_data(data_f),
      .rx_data_valid(valid_f), .rx_data_ready(ready_f),
      .frame_err(ferr_f), .overrun(ovr_f)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      vd_q <= valid_d;
      if (valid_d && !vd_q) rises_d <= rises_d + 1;
      if (ferr_d) ferr_d_n <= ferr_d_n + 1;
      if (ovr_d) ovr_d_n <= ovr_d_n + 1;
      if (ferr_f) ferr_f_n <= ferr_f_n + 1;
      if (ovr_f) ovr_f_n <= ovr_f_n + 1;
      if (valid_f && ready_f) got_q.push_back(data_f);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   task automatic put(input bit f, input logic v);
      if (f) rx_f = v;
      else rx_d = v;
      repeat (f ? CYC_F : CYC_D) @(posedge clk);
      #1;
   endtask

   task automatic send(input bit f, input logic [7:0] b, input logic stop);
      @(posedge clk);
      #1;
      put(f, 1'b0);
      for (int i = 0; i < 8; i++) put(f, b[i]);
      put(f, stop);
      if (f) rx_f = 1'b1;
      else rx_d = 1'b1;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   vec_t       vecs[5];
   logic [7:0] exp_q[$];
   int         r0, f0, o0, base, lat, exp_ferr;
   logic [7:0] rb;
   logic       rs;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vecs[0] = '{8'h55, 1'b1, 1'b1, 1'b1, 8'h55, 1, 0, 0};
      vecs[1] = '{8'hA3, 1'b0, 1'b0, 1'b0, 8'h55, 0, 1, 0};
      vecs[2] = '{8'h3C, 1'b1, 1'b1, 1'b1, 8'h3C, 1, 0, 0};
      vecs[3] = '{8'h11, 1'b1, 1'b0, 1'b1, 8'h11, 1, 0, 0};
      vecs[4] = '{8'h22, 1'b1, 1'b1, 1'b1, 8'h22, 0, 0, 1};
      rst_n = 1'b0; rx_d = 1'b1; rx_f = 1'b1; ready_d = 1'b0; ready_f = 1'b0;
      idle(5);
      check("reset data_d", data_d, 8'h00);
      check("reset valid_d", valid_d, 0);
      check("reset ferr_d", ferr_d, 0);
      check("reset ovr_d", ovr_d, 0);
      check("reset data_f", data_f, 8'h00);
      check("reset valid_f", valid_f, 0);
      rst_n = 1'b1;
      idle(5);

      // directed frames at the default 434 clocks per bit
      for (int i = 0; i < 5; i++) begin
         r0 = rises_d; f0 = ferr_d_n; o0 = ovr_d_n;
         send(1'b0, vecs[i].b, vecs[i].stop);
         idle(4);
         check($sformatf("vec%0d valid", i), valid_d, vecs[i].exp_valid);
         check($sformatf("vec%0d data", i), data_d, vecs[i].exp_data);
         check($sformatf("vec%0d rises", i), rises_d - r0, vecs[i].exp_rise);
         check($sformatf("vec%0d frame_err", i), ferr_d_n - f0, vecs[i].exp_ferr);
         check($sformatf("vec%0d overrun", i), ovr_d_n - o0, vecs[i].exp_ovr);
         if (vecs[i].consume) begin
            ready_d = 1'b1;
            idle(1);
            ready_d = 1'b0;
            check($sformatf("vec%0d consumed", i), valid_d, 0);
         end
      end

      r0 = rises_d; f0 = ferr_d_n; o0 = ovr_d_n;
      rx_d = 1'b0;
      idle(100);
      rx_d = 1'b1;
      idle(CYC_D);
      check("glitch valid", valid_d, 0);
      check("glitch rises", rises_d - r0, 0);
      check("glitch frame_err", ferr_d_n - f0, 0);
      check("glitch overrun", ovr_d_n - o0, 0);

      // reset in the middle of bit 4 of 0xFF
      r0 = rises_d; f0 = ferr_d_n; o0 = ovr_d_n;
      put(1'b0, 1'b0);
      for (int i = 0; i < 4; i++) put(1'b0, 1'b1);
      repeat (CYC_D / 2) @(posedge clk);
      #1 rst_n = 1'b0;
      #2;
      check("midreset data", data_d, 8'h00);
      check("midreset valid", valid_d, 0);
      idle(3);
      rst_n = 1'b1;
      idle(2 * CYC_D);
      send(1'b0, 8'h81, 1'b1);
      idle(4);
      check("after reset valid", valid_d, 1);
      check("after reset data", data_d, 8'h81);
      check("after reset rises", rises_d - r0, 1);
      check("after reset frame_err", ferr_d_n - f0, 0);
      check("after reset overrun", ovr_d_n - o0, 0);

      // commit coinciding with a consume, using the measured commit latency
      send(1'b1, 8'h5A, 1'b1);
      idle(4);
      check("hold valid", valid_f, 1);
      o0 = ovr_f_n;
      lat = 0;
      fork
         send(1'b1, 8'hC3, 1'b1);
         while (data_f !== 8'hC3 && lat < 400) begin
            @(posedge clk);
            #1;
            lat++;
         end
      join
      check("commit seen", lat < 400, 1);
      check("overwrite overrun", ovr_f_n - o0, 1);
      check("overwrite valid", valid_f, 1);
      check("overwrite data", data_f, 8'hC3);
      ready_f = 1'b1;
      idle(1);
      ready_f = 1'b0;
      check("overwrite consumed", valid_f, 0);
      check("overwrite got", got_q.size() == 1 ? got_q[0] : 32'hxxxx, 8'hC3);
      send(1'b1, 8'h96, 1'b1);
      idle(4);
      o0 = ovr_f_n;
      fork
         send(1'b1, 8'h69, 1'b1);
         begin
            repeat (lat - 1) @(posedge clk);
            #1 ready_f = 1'b1;
            @(posedge clk);
            #1 ready_f = 1'b0;
         end
      join
      check("same-cycle overrun", ovr_f_n - o0, 0);
      check("same-cycle valid", valid_f, 1);
      check("same-cycle data", data_f, 8'h69);
      check("same-cycle got", got_q.size() == 2 ? got_q[1] : 32'hxxxx, 8'h96);

      // line held low: one frame error, no retrigger until it rises and falls again
      ready_f = 1'b1;
      idle(2);
      base = got_q.size(); f0 = ferr_f_n;
      rx_f = 1'b0;
      idle(30 * CYC_F);
      rx_f = 1'b1;
      idle(3 * CYC_F);
      check("break frame_err", ferr_f_n - f0, 1);
      check("break no byte", got_q.size() - base, 0);
      send(1'b1, 8'h42, 1'b1);
      idle(4);
      check("after break byte", got_q.size() == base + 1 ? got_q[base] : 32'hxxxx, 8'h42);

      // random frames, ready held high
      base = got_q.size(); f0 = ferr_f_n; o0 = ovr_f_n; exp_ferr = 0;
      exp_q.delete();
      for (int i = 0; i < 40; i++) begin
         rb = 8'($urandom);
         rs = $urandom_range(0, 7) != 0;
         send(1'b1, rb, rs);
         if (rs) exp_q.push_back(rb);
         else exp_ferr++;
         idle($urandom_range(1, 20));
      end
      idle(CYC_F);
      check("random count", got_q.size() - base, exp_q.size());
      check("random frame_err", ferr_f_n - f0, exp_ferr);
      check("random overrun", ovr_f_n - o0, 0);
      for (int i = 0; i < exp_q.size(); i++)
         check($sformatf("random byte %0d", i), base + i < got_q.size() ? got_q[base + i] : 32'hxxxx, exp_q[i]);

      // loopback of every byte value from a behavioural transmitter
      base = got_q.size(); f0 = ferr_f_n; o0 = ovr_f_n;
      for (int i = 0; i < 256; i++) send(1'b1, 8'(i), 1'b1);
      idle(CYC_F);
      check("loopback count", got_q.size() - base, 256);
      check("loopback frame_err", ferr_f_n - f0, 0);
      check("loopback overrun", ovr_f_n - o0, 0);
      for (int i = 0; i < 256; i++)
         check($sformatf("loopback byte %0d", i), base + i < got_q.size() ? got_q[base + i] : 32'hxxxx, i);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLK_FREQUENCY, default 50: clock frequency in MHz.
REQ-002 Parameter BAUD_RATE, default 115200: serial baud rate.
REQ-003 One clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  clock; all logic on rising edge.
REQ-005 rst_n  input  1  asynchronous reset, active low.
REQ-006 rx_pin  input  1  asynchronous serial line; idle high, 8N1, LSB first.
REQ-007 rx_data  output  8  received byte; stable while rx_data_valid=1.
REQ-008 rx_data_valid  output  1  rx_data holds an unconsumed byte.
REQ-009 rx_data_ready  input  1  consumer accepts rx_data this cycle.
REQ-010 frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-011 overrun  output  1  one-cycle pulse: unconsumed byte overwritten.

Function
REQ-012 The block SHALL compute CYCLE = CLK_FREQUENCY*1000000/BAUD_RATE (integer division); CYCLE SHALL be >= 8 and < 65536, with a 16-bit cycle counter.
REQ-013 rx_pin SHALL pass through a 2-flop synchronizer, both flops reset to 1; all decisions use the synchronized value (rx_s) only.
REQ-014 States SHALL be IDLE, START, REC_BYTE, STOP; the counter clears on every state change.
REQ-015 IDLE -> START on a falling edge of rx_s (previous 1, current 0).
REQ-016 START: at cycle_cnt == CYCLE/2-1 -> REC_BYTE if rx_s==0, else -> IDLE (glitch rejected, no outputs change).
REQ-017 REC_BYTE: at cycle_cnt == CYCLE-1, rx_s SHALL be shifted into bit[bit_cnt], bit_cnt increments and cycle_cnt wraps to 0; after bit 7 -> STOP.
REQ-018 STOP: at cycle_cnt == CYCLE-1 (mid stop bit), -> IDLE unconditionally; if rx_s==1 the byte is committed, else frame_err pulses for one cycle and the byte is discarded.
REQ-019 Commit SHALL load rx_data and set rx_data_valid on the next clock edge after the stop sample.
REQ-020 rx_data_valid SHALL clear on the edge after a cycle with rx_data_valid=1 and rx_data_ready=1; rx_data_ready is ignored while rx_data_valid=0.
REQ-021 Commit while rx_data_valid=1 and rx_data_ready=0: rx_data is overwritten, rx_data_valid stays 1, overrun pulses one cycle.
REQ-022 Commit in the same cycle as a consume: the new byte loads, rx_data_valid stays 1, and overrun stays 0.
REQ-023 Reception SHALL be independent of the consumer; the receiver never stalls.
REQ-024 A line held low in IDLE SHALL NOT retrigger until rx_s returns high and falls again.

Reset
REQ-025 On rst_n=0: state=IDLE, counters=0, shift register=0, rx_data=0x00, rx_data_valid=0, frame_err=0, overrun=0, synchronizer flops=1.
REQ-026 Reset mid-frame SHALL abandon the frame; after release, the block waits for a fresh falling edge and never commits a partial byte.

Structure
REQ-027 State encodings (shared with uart_tx) and the CYCLE formula SHALL live in a shared package/include, uart_pkg.
REQ-028 The synchronizer SHALL be one sub-module, sync_2ff (reset value parameter, default 1); all other logic stays in uart_rx.

Verification
REQ-029 Use the defaults (CYCLE=434). Drive 0x55 at 115200 baud -> exactly one rx_data_valid rise with rx_data=0x55, and frame_err=0, overrun=0.
REQ-030 Drive a 100-cycle low glitch on an idle line -> state returns to IDLE, with no valid, frame_err, or overrun.
REQ-031 Drive 0xA3 with the stop bit forced low -> one frame_err pulse, rx_data_valid stays 0, and the next good byte 0x3C is received correctly.
REQ-032 Drive 0x11 then 0x22 back to back with rx_data_ready=0 -> one overrun pulse, rx_data=0x22; drive ready=1 for one cycle -> valid clears.
REQ-033 Assert rst_n low during bit 4 of 0xFF, then release and send 0x81 -> only 0x81 is delivered.
REQ-034 Loopback: connect uart_tx tx_pin to rx_pin, send 256 bytes 0x00..0xFF with ready tied high -> all bytes are received in order, with no errors.
